// File: rtl/iterative_multiplier_if.sv
// rtl/iterative_multiplier_if.sv - request/result bundle for iterative_multiplier
interface iterative_multiplier_if #(
   parameter int WIDTH = 32
);
   logic               mult_begin;
   logic               is_signed;
   logic [WIDTH-1:0]   operand1;
   logic [WIDTH-1:0]   operand2;
   logic [2*WIDTH-1:0] product;
   logic               mult_end;
   logic               busy;

   modport master (
      output mult_begin, is_signed, operand1, operand2,
      input  product, mult_end, busy
   );

   modport slave (
      input  mult_begin, is_signed, operand1, operand2,
      output product, mult_end, busy
   );
endinterface

// File: rtl/iterative_multiplier.sv
// rtl/iterative_multiplier.sv - shift-add multiplier, BITS_PER_CYCLE bits per edge, signed/unsigned
// Optional MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module iterative_multiplier #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                 clk,
   input  logic                 resetn,
   iterative_multiplier_if.slave mul
);
   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);
   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    product_q, product_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CW-1:0]    count_q, count_d;
   logic             sign_q, sign_d;

   logic [WIDTH-1:0] mag1, mag2;
   logic [PW-1:0]    partial, acc_sum;
   logic [WIDTH-1:0] mplier_shift;
   logic             last_iter;

   // Negating -2^(WIDTH-1) yields 2^(WIDTH-1), which is exact when read as unsigned.
   assign mag1 = (mul.is_signed && mul.operand1[WIDTH-1]) ? -mul.operand1 : mul.operand1;
   assign mag2 = (mul.is_signed && mul.operand2[WIDTH-1]) ? -mul.operand2 : mul.operand2;

   always_comb begin
      partial = '0;
      for (int b = 0; b < BITS_PER_CYCLE; b++) begin
         if (mplier_q[b]) begin
            partial = partial + (mcand_q << b);
         end
      end
   end

   assign acc_sum      = acc_q + partial;
   assign mplier_shift = mplier_q >> BITS_PER_CYCLE;

`ifdef MULT_EARLY_TERM_EN
   assign last_iter = (count_q == CW'(1)) || (mplier_shift == '0);
`else
   assign last_iter = (count_q == CW'(1));
`endif

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      product_d = product_q;
      mplier_d  = mplier_q;
      count_d   = count_q;
      sign_d    = sign_q;
      case (state_q)
         IDLE: begin
            if (mul.mult_begin) begin
               mcand_d  = {{WIDTH{1'b0}}, mag1};
               mplier_d = mag2;
               sign_d   = mul.is_signed & (mul.operand1[WIDTH-1] ^ mul.operand2[WIDTH-1]);
               acc_d    = '0;
               count_d  = CW'(N);
               state_d  = CALC;
            end
         end
         CALC: begin
            if (!mul.mult_begin) begin
               state_d = IDLE;
            end else begin
               acc_d    = acc_sum;
               mcand_d  = mcand_q << BITS_PER_CYCLE;
               mplier_d = mplier_shift;
               count_d  = count_q - CW'(1);
               if (last_iter) begin
                  product_d = sign_q ? -acc_sum : acc_sum;
                  state_d   = DONE;
               end
            end
         end
         DONE: begin
            // Stay here until the requester releases; no back-to-back restart.
            if (!mul.mult_begin) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         acc_q     <= '0;
         product_q <= '0;
         mplier_q  <= '0;
         count_q   <= '0;
         sign_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         mplier_q  <= mplier_d;
         count_q   <= count_d;
         sign_q    <= sign_d;
      end
   end

   assign mul.product  = product_q;
   assign mul.mult_end = (state_q == DONE);
   assign mul.busy     = (state_q == CALC);
endmodule

// File: tb/tb_iterative_multiplier.sv
// tb/tb_iterative_multiplier.sv - vector table, corner sequences and random ops for iterative_multiplier
// Covers a 32-bit/1-bit-per-cycle and a 16-bit/4-bit-per-cycle instance.
module tb_iterative_multiplier;
   logic clk = 1'b0;
   logic resetn;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   iterative_multiplier_if #(.WIDTH(32)) ia ();
   iterative_multiplier_if #(.WIDTH(16)) ib ();

   iterative_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut_a (.clk(clk), .resetn(resetn), .mul(ia));
   iterative_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut_b (.clk(clk), .resetn(resetn), .mul(ib));

   typedef struct {
      bit          which;
      bit          sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference: sign-extend to 64 bits, multiply, keep the low 2*w bits.
   function automatic logic [63:0] ref_prod(input int w, input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p;
      logic [63:0] r;
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
      if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
      if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
      p = sa * sb;
      r = p;
      if (w < 32) r = r & ((64'd1 << (2 * w)) - 64'd1);
      return r;
   endfunction

   function automatic int ref_lat(input int w, input int bpc, input bit sgn, input logic [31:0] b);
      logic [63:0] m;
      int top, l;
      m = {32'b0, b};
      if (sgn && b[w-1]) m = (64'd1 << w) - m;
      top = 0;
      for (int i = 0; i < w; i++) if (m[i]) top = i + 1;
      l = (top + bpc - 1) / bpc;
      if (l < 1) l = 1;
`ifdef MULT_EARLY_TERM_EN
      return l;
`else
      return (l > 0) ? w / bpc : 0;
`endif
   endfunction

   task automatic drive(input bit which, input bit bg, input bit sgn, input logic [31:0] a, input logic [31:0] b);
      if (which) begin
         ib.mult_begin = bg; ib.is_signed = sgn; ib.operand1 = a[15:0]; ib.operand2 = b[15:0];
      end else begin
         ia.mult_begin = bg; ia.is_signed = sgn; ia.operand1 = a; ia.operand2 = b;
      end
   endtask

   function automatic logic [63:0] prod_of(input bit which);
      return which ? {32'b0, ib.product} : ia.product;
   endfunction

   function automatic bit end_of(input bit which);
      return which ? ib.mult_end : ia.mult_end;
   endfunction

   function automatic bit busy_of(input bit which);
      return which ? ib.busy : ia.busy;
   endfunction

   // Full operation: load, iterate (operands scrambled after load), hold in DONE, release.
   task automatic run_op(input bit which, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_p, input int exp_lat, input string name);
      int cyc;
      bit done, busy_bad;
      cyc = 0; done = 0; busy_bad = 0;
      @(negedge clk);
      drive(which, 1'b1, sgn, a, b);
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (end_of(which)) done = 1;
         else if (!busy_of(which)) busy_bad = 1;
         if (cyc == 1) drive(which, 1'b1, ~sgn, $urandom, $urandom);
      end
      chk({name, " completed"}, 64'(done), 64'd1);
      chk({name, " product"}, prod_of(which), exp_p);
      chk({name, " latency"}, 64'(cyc - 1), 64'(exp_lat));
      chk({name, " busy during calc"}, 64'(busy_bad), 64'd0);
      chk({name, " busy at done"}, 64'(busy_of(which)), 64'd0);
      @(negedge clk);
      chk({name, " done hold"}, {63'b0, end_of(which)}, 64'd1);
      chk({name, " product hold"}, prod_of(which), exp_p);
      drive(which, 1'b0, sgn, a, b);
      @(negedge clk);
      chk({name, " release"}, {63'b0, end_of(which)}, 64'd0);
      chk({name, " product after release"}, prod_of(which), exp_p);
   endtask

   initial begin
      vec_t tbl[$];
      bit seen_end;
      resetn = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      #12;
      chk("reset product a", ia.product, 64'h0);
      chk("reset mult_end a", {63'b0, ia.mult_end}, 64'h0);
      chk("reset busy a", {63'b0, ia.busy}, 64'h0);
      chk("reset product b", {32'b0, ib.product}, 64'h0);
      chk("reset busy b", {63'b0, ib.busy}, 64'h0);
      @(negedge clk);
      resetn = 1'b1;

      run_op(1'b0, 1'b0, 32'h1111, 32'h1111, 64'h0000000001234321, ref_lat(32, 1, 1'b0, 32'h1111), "plan 1111x1111");

      // Abort: drop mult_begin partway through CALC.
      seen_end = 0;
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'h1111, 32'h2222);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ia.mult_end) seen_end = 1;
      end
      drive(1'b0, 1'b0, 1'b0, 32'h1111, 32'h2222);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ia.mult_end) seen_end = 1;
      end
      chk("abort mult_end never", 64'(seen_end), 64'd0);
      chk("abort busy", {63'b0, ia.busy}, 64'd0);
      chk("abort product kept", ia.product, 64'h0000000001234321);
      run_op(1'b0, 1'b0, 32'h1111, 32'h2222, 64'h0000000002468642, ref_lat(32, 1, 1'b0, 32'h2222), "rerun 1111x2222");

      // Asynchronous reset in the middle of CALC.
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'h1234, 32'h5678);
      for (int i = 0; i < 6; i++) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("async reset product", ia.product, 64'h0);
      chk("async reset mult_end", {63'b0, ia.mult_end}, 64'h0);
      chk("async reset busy", {63'b0, ia.busy}, 64'h0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      resetn = 1'b1;
      run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'h7, 64'hFFFFFFFFFFFFFFCF, ref_lat(32, 1, 1'b1, 32'h7), "post reset -7x7");

      tbl.push_back('{1'b0, 1'b0, 32'h00000002, 32'hFFFFFFFF, 64'h00000001FFFFFFFE});
      tbl.push_back('{1'b0, 1'b1, 32'h00000002, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFE});
      tbl.push_back('{1'b0, 1'b1, 32'h00000002, 32'h80000000, 64'hFFFFFFFF00000000});
      tbl.push_back('{1'b0, 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000});
      tbl.push_back('{1'b0, 1'b0, 32'h00000002, 32'h80000000, 64'h0000000100000000});
      tbl.push_back('{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001});
      tbl.push_back('{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001});
      tbl.push_back('{1'b0, 1'b0, 32'h12345678, 32'h00000000, 64'h0000000000000000});
      tbl.push_back('{1'b0, 1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000});
      tbl.push_back('{1'b1, 1'b1, 32'h0000FFFF, 32'h00000003, 64'h00000000FFFFFFFD});
      tbl.push_back('{1'b1, 1'b0, 32'h00001234, 32'h00000001, 64'h0000000000001234});
      tbl.push_back('{1'b1, 1'b1, 32'h00008000, 32'h00008000, 64'h0000000040000000});
      tbl.push_back('{1'b1, 1'b0, 32'h0000FFFF, 32'h0000FFFF, 64'h00000000FFFE0001});
      tbl.push_back('{1'b1, 1'b1, 32'h00007FFF, 32'h00008000, 64'h00000000C0008000});
      foreach (tbl[i]) begin
         run_op(tbl[i].which, tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].p,
                tbl[i].which ? ref_lat(16, 4, tbl[i].sgn, tbl[i].b) : ref_lat(32, 1, tbl[i].sgn, tbl[i].b),
                $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 50; i++) begin
         bit w, s;
         logic [31:0] a, b;
         w = 1'($urandom_range(0, 1));
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         if (w) begin
            a = a & 32'hFFFF;
            b = b & 32'hFFFF;
         end
         run_op(w, s, a, b, ref_prod(w ? 16 : 32, s, a, b),
                w ? ref_lat(16, 4, s, b) : ref_lat(32, 1, s, b), $sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/iterative_multiplier.md
Name: iterative_multiplier

Overview:
Parametrised sequential shift-add multiplier; successor to the fixed 32-bit iterative multiplier, keeping its level-style mult_begin/mult_end handshake. Adds configurable operand width, configurable bits retired per cycle, a per-operation signed/unsigned mode, abort on early mult_begin deassertion and an explicit busy flag. Sits beside the ALU as the multi-cycle multiply unit.

Parameters:
WIDTH, 32, operand width in bits; even, >= 4.
BITS_PER_CYCLE, 1, multiplier bits retired per iteration; 1, 2 or 4; must divide WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge.
resetn  input  1  asynchronous, active-low reset.
mult_begin  input  1  level request; high starts and holds an operation; low aborts or releases.
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at load edge only.
operand1  input  WIDTH  multiplicand; sampled at load edge only.
operand2  input  WIDTH  multiplier; sampled at load edge only.
product  output  2*WIDTH  registered result; holds last completed value.
mult_end  output  1  high while result valid and mult_begin still high.
busy  output  1  high while iterating (CALC).

Behaviour:
- Reset (resetn=0, async): state=IDLE, product=0, mult_end=0, busy=0, internal registers cleared. Reset mid-CALC discards operation; product reads 0.
- N = WIDTH/BITS_PER_CYCLE iterations.
- IDLE: edge with mult_begin=1 = load edge: latch |operand1|, |operand2| (magnitudes if is_signed, raw otherwise), result sign = msb1 XOR msb2 (is_signed only, else 0), accumulator=0, count=N -> CALC, busy=1.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held exactly in WIDTH-bit unsigned register; no overflow.
- CALC, mult_begin=1: each edge adds multiplicand times low BITS_PER_CYCLE multiplier bits, shifted by retired-bit position, into 2*WIDTH accumulator; multiplier shifts right by BITS_PER_CYCLE; count decrements.
- Final iteration edge (count==1): product = sign ? -(accumulator) : accumulator, two's complement mod 2^(2*WIDTH); -> DONE, mult_end=1, busy=0.
- mult_end first high N edges after load edge (WIDTH=32, BPC=1: 32 cycles).
- CALC, mult_begin=0 at any edge: abort -> IDLE, busy=0, product unchanged, mult_end stays 0.
- DONE: hold mult_end=1 and product while mult_begin=1; no restart. Edge with mult_begin=0 -> IDLE, mult_end=0 at that edge.
- New operation requires at least one edge with mult_begin=0 (pass through IDLE).
- Operand/is_signed changes after load edge ignored.
- product changes only at completion edge or reset.

Optional Feature:
MULT_EARLY_TERM_EN: when defined, each CALC edge also checks post-shift multiplier register; if zero, completes at that edge (same sign fix-up, -> DONE). Latency = max(1, ceil(index of highest set magnitude bit of operand2 +1 / BITS_PER_CYCLE)); operand2 == 0 completes on first CALC edge. Without macro: latency always N, data independent.

Test Plan:
- Unsigned, WIDTH=32, BPC=1: 0x00001111*0x00001111, mult_begin held -> product=0x0000000001234321, mult_end exactly 32 cycles after load edge, busy high those 32 cycles.
- Unsigned 0x00000002*0xFFFFFFFF -> 0x00000001FFFFFFFE; same with is_signed=1 -> 0xFFFFFFFFFFFFFFFE.
- Signed 0x00000002*0x80000000 -> 0xFFFFFFFF00000000; signed 0x80000000*0x80000000 -> 0x4000000000000000; unsigned 0x00000002*0x80000000 -> 0x0000000100000000.
- Abort: start 0x1111*0x2222 after previous 0x01234321 result, drop mult_begin at cycle 10 -> IDLE, mult_end never high, product stays 0x0000000001234321; rerun to completion -> 0x0000000002468642.
- Reset: resetn low at cycle 5 of CALC -> product=0, mult_end=0, busy=0 immediately (async); next op completes normally.
- BPC=4, WIDTH=16: signed 0xFFFF*0x0003 -> 0xFFFFFFFD after 4 cycles; with MULT_EARLY_TERM_EN, unsigned 0x1234*0x0001 -> 0x00001234 after 1 cycle.
